// File: rtl/message_serializer_pkg.sv
// Shared definitions for the message serializer: controller state encoding,
// parameter legality check and counter sizing helper.
package message_serializer_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic bit params_legal(input int data_w, input int shift_w,
                                        input int hold_cycles, input int lsb_first);
        bit ok;
        ok = 1'b1;
        if (shift_w < 1 || data_w < 1) begin
            ok = 1'b0;
        end else if ((data_w % shift_w) != 0) begin
            ok = 1'b0;
        end else begin
            ok = 1'b1;
        end
        if (hold_cycles < 2 || (lsb_first != 0 && lsb_first != 1)) begin
            ok = 1'b0;
        end else begin
            ok = ok;
        end
        return ok;
    endfunction

    // A counter over n values never shrinks below one bit, even for n == 1.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/message_serializer_mod_counter.sv
// Modulo counter: counts 0..MAX while enabled, wraps to 0, flags co at MAX.
// Synchronous clear wins over enable.
module mod_counter #(
    parameter int WIDTH = 2,
    parameter int MAX   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             co
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    // Count register with async active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (co) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + WIDTH'(1);
            end
        end else begin
            cnt <= cnt;
        end
    end

    assign co = (cnt == MAX_V);

endmodule

// File: rtl/message_serializer.sv
// Captures a DATA_W-bit message on start and presents it as NSYM symbols of
// SHIFT_W bits, each held HOLD_CYCLES clocks; done pulses after the last one.
module message_serializer
    import message_serializer_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SHIFT_W     = 1,
    parameter int HOLD_CYCLES = 4,
    parameter int LSB_FIRST   = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DATA_W-1:0]  msg_in,
    input  logic               abort,
    output logic [SHIFT_W-1:0] ser_out,
    output logic               ser_valid,
    output logic               sym_last,
    output logic               busy,
    output logic               done
);

    localparam int NSYM   = DATA_W / SHIFT_W;
    localparam int HOLD_W = $clog2(HOLD_CYCLES);
    localparam int SYM_W  = cnt_width(NSYM);

    if (!params_legal(DATA_W, SHIFT_W, HOLD_CYCLES, LSB_FIRST)) begin : g_param_check
        $error("message_serializer: illegal DATA_W/SHIFT_W/HOLD_CYCLES/LSB_FIRST");
    end

    state_e              state_q;
    logic [DATA_W-1:0]   shreg_q;
    logic [DATA_W-1:0]   shifted_s;
    logic                hold_clr_s;
    logic                hold_en_s;
    logic                hold_co_s;
    logic                sym_clr_s;
    logic                sym_en_s;
    logic                sym_co_s;
    logic [SYM_W-1:0]    sym_cnt_unused_s;
    logic [HOLD_W-1:0]   hold_cnt_unused_s;

    // Hold counter ends each symbol's HOLD phase one cycle early; SHIFT is the last cycle.
    mod_counter #(.WIDTH(HOLD_W), .MAX(HOLD_CYCLES - 2)) u_hold_cnt (
        .clk (clk),
        .rst (rst),
        .clr (hold_clr_s),
        .en  (hold_en_s),
        .cnt (hold_cnt_unused_s),
        .co  (hold_co_s)
    );

    mod_counter #(.WIDTH(SYM_W), .MAX(NSYM - 1)) u_sym_cnt (
        .clk (clk),
        .rst (rst),
        .clr (sym_clr_s),
        .en  (sym_en_s),
        .cnt (sym_cnt_unused_s),
        .co  (sym_co_s)
    );

    // Counter controls; an abort clears both counters.
    always_comb begin
        hold_clr_s = 1'b0;
        hold_en_s  = 1'b0;
        sym_clr_s  = 1'b0;
        sym_en_s   = 1'b0;
        case (state_q)
            ST_INIT: begin
                hold_clr_s = 1'b1;
                sym_clr_s  = 1'b1;
            end
            ST_HOLD: begin
                if (abort) begin
                    hold_clr_s = 1'b1;
                    sym_clr_s  = 1'b1;
                end else begin
                    hold_en_s  = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    hold_clr_s = 1'b1;
                    sym_clr_s  = 1'b1;
                end else begin
                    hold_clr_s = 1'b1;
                    sym_en_s   = 1'b1;
                end
            end
            default: begin
                hold_clr_s = 1'b0;
            end
        endcase
    end

    // Zero-fill shift that moves the next symbol into the output slot.
    always_comb begin
        if (LSB_FIRST != 0) begin
            shifted_s = shreg_q >> SHIFT_W;
        end else begin
            shifted_s = shreg_q << SHIFT_W;
        end
    end

    // Controller FSM and message shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        shreg_q <= msg_in;
                        state_q <= ST_INIT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_INIT, ST_HOLD: begin
                    if (abort) begin
                        shreg_q <= '0;
                        state_q <= ST_IDLE;
                    end else if (state_q == ST_INIT) begin
                        state_q <= ST_HOLD;
                    end else if (hold_co_s) begin
                        state_q <= ST_SHIFT;
                    end else begin
                        state_q <= ST_HOLD;
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        shreg_q <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        shreg_q <= shifted_s;
                        state_q <= sym_co_s ? ST_DONE : ST_HOLD;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Output slot is the end of the register the shift moves away from.
    always_comb begin
        if (LSB_FIRST != 0) begin
            ser_out = shreg_q[SHIFT_W-1:0];
        end else begin
            ser_out = shreg_q[DATA_W-1 -: SHIFT_W];
        end
    end

    assign ser_valid = (state_q == ST_HOLD) || (state_q == ST_SHIFT);
    assign sym_last  = ser_valid && sym_co_s;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

endmodule
